// File: rtl/udiv_arb_pkg.sv
// Shared constants and the pipeline stage record for the reciprocal-multiply divider arbiter.
package udiv_arb_pkg;
   localparam int CODE_W         = 8;
   localparam int RECIP_W        = 16;
   localparam int N_REQ_DEF      = 4;
   localparam int DIVIDEND_W_DEF = 16;
   localparam int ID_W_DEF       = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

   // Sized for the default requester count and dividend width.
   typedef struct packed {
      logic                      valid;
      logic [ID_W_DEF-1:0]       id;
      logic [DIVIDEND_W_DEF-1:0] dividend;
      logic [CODE_W-1:0]         code;
      logic [RECIP_W-1:0]        recip;
   } stage_t;
endpackage

// File: rtl/udiv_lut_arbiter_recip_lut.sv
// Combinational Q0.16 reciprocal table: recip = floor(65536 / (code + 1)), code 0 saturates to all-ones.
module recip_lut
   import udiv_arb_pkg::*;
(
   input  logic [CODE_W-1:0]  code,
   output logic [RECIP_W-1:0] recip
);
   logic [RECIP_W-1:0] recip_rom [2**CODE_W];

   // Entries are elaboration-time constants, so this folds into a ROM.
   for (genvar g = 0; g < 2**CODE_W; g++) begin : g_rom
      if (g == 0) begin : g_sat
         assign recip_rom[g] = '1;
      end else begin : g_div
         assign recip_rom[g] = RECIP_W'((1 << RECIP_W) / (g + 1));
      end
   end

   assign recip = recip_rom[code];
endmodule

// File: rtl/udiv_lut_arbiter_rr_arbiter.sv
// Round-robin grant: the first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);
   int idx;

   // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      for (int off = N - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end
endmodule

// File: rtl/udiv_lut_arbiter.sv
// Shares one reciprocal-multiply divider among N_REQ requesters through a 3-stage stallable pipeline.
module udiv_lut_arbiter
   import udiv_arb_pkg::*;
#(
   parameter  int N_REQ      = N_REQ_DEF,
   parameter  int DIVIDEND_W = DIVIDEND_W_DEF,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_REQ-1:0]                   req_valid,
   output logic [N_REQ-1:0]                   req_ready,
   input  logic [N_REQ-1:0][DIVIDEND_W-1:0]   req_dividend,
   input  logic [N_REQ-1:0][CODE_W-1:0]       req_code,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [ID_W-1:0]                    res_id,
   output logic [DIVIDEND_W-1:0]              res_quotient,
   output logic                               busy
);
   logic [ID_W-1:0]       ptr;
   logic [N_REQ-1:0]      grant;
   logic [ID_W-1:0]       grant_idx;
   logic                  stall;
   logic                  advance;
   logic [RECIP_W-1:0]    recip_p0;
   stage_t                s_p0;
   stage_t                s_p1;
   logic                  vld_p0;
   logic                  vld_p1;
   logic                  vld_p2;
   logic [ID_W-1:0]       id_p2;
   logic [DIVIDEND_W-1:0] quot_p2;

   // Code 0 means divide by one; its table entry is saturated, so the product is bypassed.
   function automatic logic [DIVIDEND_W-1:0] scale_trunc(
      input logic [DIVIDEND_W-1:0] dividend,
      input logic [RECIP_W-1:0]    recip,
      input logic                  bypass
   );
      logic [DIVIDEND_W+RECIP_W-1:0] prod;
      prod = {{RECIP_W{1'b0}}, dividend} * {{DIVIDEND_W{1'b0}}, recip};
      return bypass ? dividend : prod[DIVIDEND_W+RECIP_W-1:RECIP_W];
   endfunction

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   recip_lut u_lut (
      .code  (s_p0.code),
      .recip (recip_p0)
   );

   assign vld_p0       = s_p0.valid;
   assign vld_p1       = s_p1.valid;
   assign stall        = vld_p2 && !res_ready;
   assign advance      = !stall;
   assign req_ready    = (rst || stall) ? '0 : grant;
   assign res_valid    = vld_p2;
   assign res_id       = id_p2;
   assign res_quotient = quot_p2;
   assign busy         = vld_p0 || vld_p1 || vld_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         s_p0    <= '0;
         s_p1    <= '0;
         vld_p2  <= 1'b0;
         id_p2   <= '0;
         quot_p2 <= '0;
      end else if (advance) begin
         if (|grant) ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
         // p0: registered grant and its operands
         s_p0.valid    <= |grant;
         s_p0.id       <= grant_idx;
         s_p0.dividend <= req_dividend[grant_idx];
         s_p0.code     <= req_code[grant_idx];
         s_p0.recip    <= '0;
         // p1: reciprocal looked up from the p0 code
         s_p1          <= s_p0;
         s_p1.recip    <= recip_p0;
         // p2: truncated quotient
         vld_p2        <= vld_p1;
         id_p2         <= s_p1.id;
         quot_p2       <= scale_trunc(s_p1.dividend, s_p1.recip, s_p1.code == '0);
      end
   end
endmodule

// File: tb/tb_udiv_lut_arbiter.sv
// Scoreboard bench for udiv_lut_arbiter: directed cases, backpressure, mid-flight reset and random traffic.
module tb_udiv_lut_arbiter;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0][15:0] req_dividend = '0;
   logic [N-1:0][7:0] req_code = '0;
   logic              res_valid;
   logic              res_ready = 1'b1;
   logic [1:0]        res_id;
   logic [15:0]       res_quotient;
   logic              busy;

   udiv_lut_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dividend (req_dividend),
      .req_code     (req_code),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_id       (res_id),
      .res_quotient (res_quotient),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int quot;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   id_log[$];
   int   cyc_log[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   ptr_m = 0;
   int   acc_cnt = 0;
   int   last_id = -1;
   int   last_quot = -1;
   bit   lat_mode = 1'b1;
   bit   stall_prev = 1'b0;
   int   held_id = 0;
   int   held_q = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: quotient = floor(dividend * floor(65536/(code+1)) / 65536); divide-by-one is exact.
   function automatic int model_q(input int d, input int c);
      longint r;
      if (c == 0) return d;
      r = 65536 / (c + 1);
      return int'((longint'(d) * r) >> 16);
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: inputs change just after posedge, so the negedge sees what the next posedge will act on.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      bit   st;
      int   k;
      exp_t e;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         st = res_valid && !res_ready;
         check("busy", busy, exp_q.size() > 0);
         if (lat_mode)
            check("res_valid_timing", res_valid, (exp_q.size() > 0) && (exp_q[0].cyc + 3 <= cyc));
         exp_rdy = '0;
         if (!st) begin
            for (int off = 0; off < N; off++) begin
               k = (ptr_m + off) % N;
               if (req_valid[k]) begin
                  exp_rdy[k] = 1'b1;
                  break;
               end
            end
         end
         check("req_ready", req_ready, exp_rdy);
         if (stall_prev) begin
            check("stall_valid", res_valid, 1);
            check("stall_id", res_id, held_id);
            check("stall_quot", res_quotient, held_q);
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", res_id, -1);
            end else begin
               e = exp_q.pop_front();
               check("res_id", res_id, e.id);
               check("res_quotient", res_quotient, e.quot);
               if (lat_mode) check("latency", cyc - e.cyc, 3);
               last_id   = int'(res_id);
               last_quot = int'(res_quotient);
               id_log.push_back(last_id);
               cyc_log.push_back(cyc);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_q.push_back('{id: i, quot: model_q(int'(req_dividend[i]), int'(req_code[i])), cyc: cyc});
               ptr_m = (i + 1) % N;
               acc_cnt++;
            end
         end
         stall_prev = st;
         held_id    = int'(res_id);
         held_q     = int'(res_quotient);
      end
   end

   task automatic single(input int k, input int d, input int c);
      @(posedge clk); #1;
      req_valid       = '0;
      req_valid[k]    = 1'b1;
      req_dividend[k] = 16'(d);
      req_code[k]     = 8'(c);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (5) @(posedge clk);
   endtask

   initial begin
      int start_acc;
      int budget;
      #2 rst = 1'b1;
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_quot", res_quotient, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      single(0, 1000, 3);
      check("q_r0", last_quot, 250);
      check("id_r0", last_id, 0);
      single(1, 300, 2);
      check("q_r1", last_quot, 99);
      check("id_r1", last_id, 1);
      single(2, 16'hFFFF, 0);
      check("q_r2", last_quot, 16'hFFFF);
      single(3, 16'hFFFF, 255);
      check("q_r3", last_quot, 16'h00FF);
      check("id_r3", last_id, 3);

      // All requesters continuously valid for 8 cycles.
      id_log.delete();
      cyc_log.delete();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         req_dividend[i] = 16'(1000 * (i + 1));
         req_code[i]     = 8'(i + 4);
      end
      req_valid = '1;
      repeat (8) @(posedge clk);
      #1 req_valid = '0;
      repeat (6) @(posedge clk);
      check("rr_count", id_log.size(), 8);
      if (id_log.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            check("rr_seq_id", id_log[i], i % 4);
            check("rr_back_to_back", cyc_log[i] - cyc_log[0], i);
         end
      end

      // Backpressure with three entries in flight and requester 3 waiting.
      lat_mode = 1'b0;
      id_log.delete();
      @(posedge clk); #1;
      res_ready = 1'b0;
      req_valid = 4'b0001;
      @(posedge clk); #1 req_valid = 4'b0010;
      @(posedge clk); #1 req_valid = 4'b0100;
      @(posedge clk); #1 req_valid = 4'b1000;
      repeat (5) @(posedge clk);
      check("bp_none_delivered", id_log.size(), 0);
      #1 res_ready = 1'b1;
      @(posedge clk); #1 req_valid = '0;
      repeat (6) @(posedge clk);
      check("bp_count", id_log.size(), 4);
      if (id_log.size() == 4)
         for (int i = 0; i < 4; i++) check("bp_order", id_log[i], i);

      // Reset with three entries in flight.
      @(posedge clk); #1 req_valid = 4'b0001;
      @(posedge clk); #1 req_valid = 4'b0010;
      @(posedge clk); #1 req_valid = 4'b0100;
      @(posedge clk); #3;
      req_valid = '0;
      rst = 1'b1;
      #1;
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_inflight", exp_q.size(), 3);
      exp_q.delete();
      ptr_m = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '1;
      @(negedge clk);
      check("post_rst_grant", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid = '0;
      repeat (6) @(posedge clk);

      // Random traffic with random backpressure.
      start_acc = acc_cnt;
      budget = 0;
      while (acc_cnt - start_acc < 10000 && budget < 40000) begin
         @(posedge clk); #1;
         budget++;
         for (int i = 0; i < N; i++) begin
            int sel;
            req_valid[i]    = 1'($urandom_range(0, 1));
            req_dividend[i] = 16'($urandom);
            sel = $urandom_range(0, 9);
            req_code[i] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
         end
         res_ready = ($urandom_range(0, 3) != 0);
      end
      check("random_transfers_done", (acc_cnt - start_acc) >= 10000, 1);
      @(posedge clk); #1;
      req_valid = '0;
      res_ready = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #1;
      check("drain_empty", exp_q.size(), 0);
      check("drain_busy", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/udiv_lut_arbiter.md
UDIV_LUT_ARBITER -- requirements
Module: udiv_lut_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the reciprocal divider.
REQ-002 Parameter DIVIDEND_W, default 16: dividend and quotient width.
REQ-003 The clock port SHALL be `clk  input  1  sole clock`; all logic is rising-edge.
REQ-004 The reset port SHALL be `rst  input  1  asynchronous, active-high reset`.
REQ-005 Port `req_valid  input  N_REQ`: per-requester request valid.
REQ-006 Port `req_ready  output  N_REQ`: per-requester accept; a transfer occurs when valid and ready are both high.
REQ-007 Port `req_dividend  input  N_REQ x DIVIDEND_W`: unsigned dividend per requester.
REQ-008 Port `req_code  input  N_REQ x 8`: divisor code; effective divisor = code+1.
REQ-009 Port `res_valid  output  1`: result valid.
REQ-010 Port `res_ready  input  1`: downstream accept.
REQ-011 Port `res_id  output  clog2(N_REQ)`: index of the requester that owns the result.
REQ-012 Port `res_quotient  output  DIVIDEND_W`: quotient.
REQ-013 Port `busy  output  1`: high while any pipeline stage holds a valid entry.

Function
REQ-014 The block SHALL grant at most one requester per cycle, using round-robin starting from pointer `ptr`.
REQ-015 After an accepted transfer from requester k, `ptr` SHALL become (k+1) mod N_REQ; `ptr` SHALL hold on cycles without a transfer.
REQ-016 `req_ready[i]` SHALL be high only when i is the current grant and the pipeline advances; it SHALL be combinational from req_valid, ptr and the stall signal.
REQ-017 Pipeline S1 SHALL register the grant, dividend, code and id.
REQ-018 Pipeline S2 SHALL register R = the Q0.16 reciprocal of (code+1): code 0 -> 0xFFFF, code 1 -> 0x8000, code 2 -> 0x5555, code 255 -> 0x0100; all values truncated.
REQ-019 Pipeline S3 SHALL register quotient = (dividend * R)[31:16] from a full 32-bit product.
REQ-020 Code 0 SHALL bypass the product, so quotient = dividend exactly.
REQ-021 Latency SHALL be exactly 3 cycles from the accepting edge to res_valid when there is no backpressure.
REQ-022 Throughput SHALL be 1 result per cycle.
REQ-023 Stall SHALL be defined as res_valid && !res_ready; while stalled, all stages hold and all req_ready are 0.
REQ-024 While stalled, res_id and res_quotient SHALL remain stable.
REQ-025 Results SHALL be delivered in acceptance order; none are dropped or duplicated.
REQ-026 If res_ready rises in the same cycle that a new request is valid, the pipeline SHALL advance and accept that request in the same cycle.
REQ-027 When req_valid is all zero, bubbles SHALL propagate and res_valid SHALL go low 3 cycles after the last accept.
REQ-028 A requester that drops req_valid SHALL be skipped with no penalty cycle.

Reset
REQ-029 On rst, asynchronously and immediately: all stage valids = 0, res_valid = 0, req_ready = 0, busy = 0, ptr = 0, res_id = 0, res_quotient = 0.
REQ-030 Reset mid-operation SHALL discard in-flight entries, with no result emitted for them.
REQ-031 The first accept after reset release SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-032 Package udiv_arb_pkg SHALL hold CODE_W=8, RECIP_W=16, the default N_REQ and DIVIDEND_W, and the pipeline stage struct (valid, id, dividend, code/recip).
REQ-033 The reciprocal table SHALL be the team's existing combinational 8-bit-to-16-bit reciprocal LUT, instantiated once and fed from S1.
REQ-034 Round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N; ports req, ptr, grant one-hot, grant_idx).

Verification
REQ-035 Requester 0: dividend 1000, code 3 -> res_quotient 250, res_id 0, exactly 3 cycles after accept.
REQ-036 Requester 1: dividend 300, code 2 -> 99 (truncation). Requester 2: dividend 0xFFFF, code 0 -> 0xFFFF. Requester 3: dividend 0xFFFF, code 255 -> 0x00FF.
REQ-037 All 4 req_valid held high for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3 with back-to-back res_valid.
REQ-038 res_ready low for 5 cycles with 3 entries in flight -> outputs frozen, req_ready all 0, then 3 results delivered in order with none lost.
REQ-039 rst pulsed with 3 entries in flight -> res_valid 0 immediately, busy 0, next grant goes to requester 0.
REQ-040 Random traffic and backpressure for 10k transfers -> every result equals the (dividend*R)>>16 model, and per-requester order is preserved.
